// File: rtl/nios2_cpu_mul_combine_if.sv
// Bundle between the M-stage multiplier cell and the combiner.
// It carries the partial products and control in, and the A-stage product word out.
interface nios2_cpu_mul_combine_if;
    logic        M_en;
    logic        M_mul_valid;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic [31:0] M_mul_cell_p4;
    logic        M_ctrl_mul_src1_signed;
    logic        M_ctrl_mul_src2_signed;
    logic        M_ctrl_mul_hi;
    logic [31:0] A_mul_result;
    logic [63:0] A_mul_full;
    logic        A_mul_valid;

    modport master (
        output M_en, M_mul_valid, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
               M_mul_cell_p4, M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed,
               M_ctrl_mul_hi,
        input  A_mul_result, A_mul_full, A_mul_valid
    );

    modport slave (
        input  M_en, M_mul_valid, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
               M_mul_cell_p4, M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed,
               M_ctrl_mul_hi,
        output A_mul_result, A_mul_full, A_mul_valid
    );
endinterface

// File: rtl/nios2_cpu_mul_combine.sv
// Combines the four 16x16 partial products into the 64-bit product and returns
// the selected 32-bit word. It uses one or two stages and advances only when M_en is high.
module nios2_cpu_mul_combine #(
    parameter int REG_MID = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    nios2_cpu_mul_combine_if.slave      mulIf
);

    logic [33:0] ext2;
    logic [33:0] ext3;
    logic [33:0] midComb;
    logic [63:0] baseComb;

    logic [63:0] full_q;
    logic [31:0] result_q;
    logic        valid_q;

    // The cross terms are 32-bit values that may be signed, so two guard bits keep their sum exact
    assign ext2     = {{2{mulIf.M_ctrl_mul_src2_signed & mulIf.M_mul_cell_p2[31]}}, mulIf.M_mul_cell_p2};
    assign ext3     = {{2{mulIf.M_ctrl_mul_src1_signed & mulIf.M_mul_cell_p3[31]}}, mulIf.M_mul_cell_p3};
    assign midComb  = ext2 + ext3;
    assign baseComb = {mulIf.M_mul_cell_p4, mulIf.M_mul_cell_p1};

    function automatic logic [63:0] combineFull(input logic [33:0] mid, input logic [63:0] base);
        logic [63:0] midExt;
        midExt = {{30{mid[33]}}, mid};
        return base + (midExt << 16);
    endfunction

    generate
        if (REG_MID != 0) begin : g_reg_mid
            logic [33:0] mid_q;
            logic [63:0] base_q;
            logic        hi_q;
            logic        valid1_q;
            logic [63:0] full_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    mid_q    <= '0;
                    base_q   <= '0;
                    hi_q     <= 1'b0;
                    valid1_q <= 1'b0;
                end else if (mulIf.M_en) begin
                    mid_q    <= midComb;
                    base_q   <= baseComb;
                    hi_q     <= mulIf.M_ctrl_mul_hi;
                    valid1_q <= mulIf.M_mul_valid;
                end
            end

            assign full_d = combineFull(mid_q, base_q);

            always_ff @(posedge clk) begin
                if (reset) begin
                    full_q   <= '0;
                    result_q <= '0;
                    valid_q  <= 1'b0;
                end else if (mulIf.M_en) begin
                    full_q   <= full_d;
                    result_q <= hi_q ? full_d[63:32] : full_d[31:0];
                    valid_q  <= valid1_q;
                end
            end
        end else begin : g_single
            logic [63:0] full_d;

            assign full_d = combineFull(midComb, baseComb);

            always_ff @(posedge clk) begin
                if (reset) begin
                    full_q   <= '0;
                    result_q <= '0;
                    valid_q  <= 1'b0;
                end else if (mulIf.M_en) begin
                    full_q   <= full_d;
                    result_q <= mulIf.M_ctrl_mul_hi ? full_d[63:32] : full_d[31:0];
                    valid_q  <= mulIf.M_mul_valid;
                end
            end
        end
    endgenerate

    assign mulIf.A_mul_full   = full_q;
    assign mulIf.A_mul_result = result_q;
    assign mulIf.A_mul_valid  = valid_q;

endmodule

// File: tb/tb_nios2_cpu_mul_combine.sv
// Bench for both combiner depths, checked against a true 64-bit multiply of the source operands.
// Both instances receive the same stimulus, and each cycle's outputs are compared with a delay-line model.
module tb_nios2_cpu_mul_combine;

    logic clk;
    logic reset;

    nios2_cpu_mul_combine_if ifR1 ();
    nios2_cpu_mul_combine_if ifR0 ();

    nios2_cpu_mul_combine #(.REG_MID(1)) dutR1 (.clk(clk), .reset(reset), .mulIf(ifR1.slave));
    nios2_cpu_mul_combine #(.REG_MID(0)) dutR0 (.clk(clk), .reset(reset), .mulIf(ifR0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          known;
        logic [63:0] full;
        logic [31:0] res;
    } expT;

    expT mdlR1S1;
    expT mdlR1S2;
    expT mdlR0;

    int compareCount = 0;
    int mismatchCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Each operation is described by its source operands. The bench forms the cell's partial products and the exact product.
    task automatic applyStimulus(input bit en, input bit vld, input bit rst,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input bit sg1, input bit sg2, input bit hi);
        logic [31:0] l1, h1, l2, h2;
        logic [31:0] p1, p2, p3, p4;
        logic [63:0] e1, e2, prod;
        expT item;

        l1 = {16'b0, s1[15:0]};
        l2 = {16'b0, s2[15:0]};
        h1 = sg1 ? {{16{s1[31]}}, s1[31:16]} : {16'b0, s1[31:16]};
        h2 = sg2 ? {{16{s2[31]}}, s2[31:16]} : {16'b0, s2[31:16]};
        p1 = l1 * l2;
        p2 = l1 * h2;
        p3 = h1 * l2;
        p4 = h1 * h2;
        e1 = sg1 ? {{32{s1[31]}}, s1} : {32'b0, s1};
        e2 = sg2 ? {{32{s2[31]}}, s2} : {32'b0, s2};
        prod = e1 * e2;

        reset = rst;
        ifR1.M_en = en;                    ifR0.M_en = en;
        ifR1.M_mul_valid = vld;            ifR0.M_mul_valid = vld;
        ifR1.M_mul_cell_p1 = p1;           ifR0.M_mul_cell_p1 = p1;
        ifR1.M_mul_cell_p2 = p2;           ifR0.M_mul_cell_p2 = p2;
        ifR1.M_mul_cell_p3 = p3;           ifR0.M_mul_cell_p3 = p3;
        ifR1.M_mul_cell_p4 = p4;           ifR0.M_mul_cell_p4 = p4;
        ifR1.M_ctrl_mul_src1_signed = sg1; ifR0.M_ctrl_mul_src1_signed = sg1;
        ifR1.M_ctrl_mul_src2_signed = sg2; ifR0.M_ctrl_mul_src2_signed = sg2;
        ifR1.M_ctrl_mul_hi = hi;           ifR0.M_ctrl_mul_hi = hi;

        item.v     = vld;
        item.known = vld;
        item.full  = prod;
        item.res   = hi ? prod[63:32] : prod[31:0];

        @(posedge clk);
        if (rst) begin
            mdlR1S1 = '{v: 1'b0, known: 1'b1, full: 64'h0, res: 32'h0};
            mdlR1S2 = mdlR1S1;
            mdlR0   = mdlR1S1;
        end else if (en) begin
            mdlR1S2 = mdlR1S1;
            mdlR1S1 = item;
            mdlR0   = item;
        end
        #1;
        checkOutput("r1_valid", {63'b0, ifR1.A_mul_valid}, {63'b0, mdlR1S2.v});
        checkOutput("r0_valid", {63'b0, ifR0.A_mul_valid}, {63'b0, mdlR0.v});
        if (mdlR1S2.known) begin
            checkOutput("r1_full",   ifR1.A_mul_full, mdlR1S2.full);
            checkOutput("r1_result", {32'b0, ifR1.A_mul_result}, {32'b0, mdlR1S2.res});
        end
        if (mdlR0.known) begin
            checkOutput("r0_full",   ifR0.A_mul_full, mdlR0.full);
            checkOutput("r0_result", {32'b0, ifR0.A_mul_result}, {32'b0, mdlR0.res});
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        applyStimulus(1, 1, 1, 32'd7, 32'd9, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'd0, 32'd0, 0, 0, 0);
        checkOutput("rst_r1_full", ifR1.A_mul_full, 64'h0);
        checkOutput("rst_r0_result", {32'b0, ifR0.A_mul_result}, 64'h0);

        // Directed products followed by bubbles that drain the pipe.
        applyStimulus(1, 1, 0, 32'd3, 32'd5, 0, 0, 0);
        checkOutput("r0_3x5", ifR0.A_mul_full, 64'd15);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1);
        checkOutput("r1_3x5_full", ifR1.A_mul_full, 64'd15);
        checkOutput("r1_3x5_res", {32'b0, ifR1.A_mul_result}, 64'h0000_000F);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0);
        checkOutput("r1_ss_full", ifR1.A_mul_full, 64'h1);
        checkOutput("r1_ss_hi", {32'b0, ifR1.A_mul_result}, 64'h0);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);
        checkOutput("r1_ss_lo", {32'b0, ifR1.A_mul_result}, 64'h1);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1);
        checkOutput("r1_uu_full", ifR1.A_mul_full, 64'hFFFF_FFFE_0000_0001);
        checkOutput("r1_uu_res", {32'b0, ifR1.A_mul_result}, 64'hFFFF_FFFE);
        applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);
        checkOutput("r1_su_full", ifR1.A_mul_full, 64'hFFFF_FFFF_0000_0001);
        checkOutput("r1_su_res", {32'b0, ifR1.A_mul_result}, 64'hFFFF_FFFF);
        applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);

        // Ops A, B and C, with a three-cycle stall once B is captured.
        applyStimulus(1, 1, 0, 32'd3, 32'd5, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1, 1);
            checkOutput("stall_hold_A", ifR1.A_mul_full, 64'd15);
        end
        applyStimulus(1, 1, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1, 1);
        applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);

        // A reset asserted mid-flight, together with a valid enabled input.
        applyStimulus(1, 1, 0, 32'd100, 32'd200, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'd300, 32'd400, 0, 0, 0);
        checkOutput("midrst_r1_valid", {63'b0, ifR1.A_mul_valid}, 64'h0);
        checkOutput("midrst_r0_valid", {63'b0, ifR0.A_mul_valid}, 64'h0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                          ($urandom_range(0, 49) == 0), pickOperand(), pickOperand(),
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/nios2_cpu_mul_combine.md
# nios2_cpu_mul_combine

Pipelined partial-product combiner for the Nios II CPU multiply path. Consumes the four registered 16x16 partial products (p1 = lo×lo, p2 = lo×hi, p3 = hi×lo, p4 = hi×hi) produced by the M-stage multiplier cell. Forms the full 64-bit product and delivers the low or high 32-bit word to the A stage for mul/mulxss/mulxsu/mulxuu. It advances under the same stage enable as the cell, so stalls freeze the whole multiply pipe coherently.

## Interface

Parameters
- REG_MID, default 1: 1 = register the middle-term sum (latency 2 enabled cycles); 0 = single combine stage (latency 1).

Ports
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- M_en  in  1  stage advance enable; the pipe holds all state when low.
- M_mul_valid  in  1  partial products on p1..p4 belong to a live multiply this cycle.
- M_mul_cell_p1  in  32  lo(src1)×lo(src2), always unsigned.
- M_mul_cell_p2  in  32  lo(src1)×hi(src2), two's complement iff M_ctrl_mul_src2_signed.
- M_mul_cell_p3  in  32  hi(src1)×lo(src2), two's complement iff M_ctrl_mul_src1_signed.
- M_mul_cell_p4  in  32  hi(src1)×hi(src2); only the low 32 bits are used.
- M_ctrl_mul_src1_signed  in  1  signedness of src1, aligned with p1..p4.
- M_ctrl_mul_src2_signed  in  1  signedness of src2, aligned with p1..p4.
- M_ctrl_mul_hi  in  1  1 = return bits [63:32]; 0 = return bits [31:0].
- A_mul_result  out  32  selected product word.
- A_mul_full  out  64  full product; used for debug and verification.
- A_mul_valid  out  1  A_mul_result/A_mul_full hold a completed multiply.

## Operation

- Middle sum: mid[33:0] = ext(p2) + ext(p3).
  - ext() sign-extends to 34 bits when the matching signed flag is 1; otherwise it zero-extends.
- Full product: full[63:0] = {p4, p1} + (sign-extend mid to 64 bits) << 16, taken modulo 2^64.
- Result word: A_mul_result = M_ctrl_mul_hi ? full[63:32] : full[31:0]. The hi select travels down the pipe with its operation.
- REG_MID=1:
  - Stage 1 registers mid, {p4,p1}, hi-select and valid.
  - Stage 2 registers full, the selected word and valid.
- REG_MID=0: a single register stage holds full, the selected word and valid.
- When M_en=1, each stage loads from its predecessor. Bubbles (M_mul_valid=0) propagate as valid=0; their data is don't-care but is still loaded.
- When M_en=0, every stage register holds its value, including valid. Inputs present that cycle are not captured; the cell holds them too.
- Every output comes directly from a register; there is no combinational path from input to output.
- There is no backpressure output. The CPU's stall logic is the only flow control.

## Timing

- Reset (reset=1 at an edge):
  - A_mul_result=0, A_mul_full=0, A_mul_valid=0.
  - All internal valid and data registers are cleared.
  - This takes priority over M_en.
- Latency is counted from the edge that captures M_mul_valid=1 with M_en=1:
  - REG_MID=1: the result is visible after 2 enabled edges.
  - REG_MID=0: the result is visible after 1 enabled edge.
- Stall cycles (M_en=0) add no change; the result appears after N enabled edges, not N clock edges.
- Throughput is one multiply per enabled cycle. Back-to-back operations never interfere, and each carries its own signed flags and hi select.
- Reset asserted mid-operation discards in-flight results. The first valid output after release needs a fresh input.
- Simultaneous reset and M_en=1 with valid input: reset wins and nothing is captured.
- Outputs are stable between enabled edges, so A-stage consumers may sample them during any cycle of a stall.

## Test plan

- Unsigned small operands, REG_MID=1: src 3×5 gives p1=15, p2=p3=p4=0, hi=0 → A_mul_result=0x0000000F and A_mul_full=15 exactly 2 enabled edges later, A_mul_valid=1 for one cycle.
- Signed mulxss -1×-1: p1=0xFFFE0001, p2=p3=0xFFFF0001 (both signed), p4=1 → A_mul_full=0x0000000000000001; result 0x00000000 with hi=1, 0x00000001 with hi=0.
- Unsigned mulxuu 0xFFFFFFFF×0xFFFFFFFF: p1=p2=p3=p4=0xFFFE0001, both flags 0, hi=1 → A_mul_result=0xFFFFFFFE, A_mul_full=0xFFFFFFFE00000001.
- Mixed mulxsu, src1=-1 signed × src2=0xFFFFFFFF unsigned: p1=p2=0xFFFE0001, p3=p4=0xFFFF0001, hi=1 → A_mul_result=0xFFFFFFFF, A_mul_full=0xFFFFFFFF00000001.
- Stall and back-to-back: issue ops A, B, C on consecutive enabled cycles, then drop M_en for 3 cycles after B is captured → outputs freeze during the stall. A, B and C appear in order with correct per-op hi select, and no result is duplicated or lost.
- Reset mid-flight: capture a valid op, assert reset on the next edge → A_mul_valid=0 and outputs are 0. No stale result appears afterwards. Repeat with REG_MID=0 and check a 1-edge latency.
